// File: rtl/resource_mapper_pkg.sv
// Shared constants and types for the NB-IoT uplink transmit resource mapper.
package resource_mapper_pkg;

   localparam int DATA_W     = 16;
   localparam int N_FFT      = 16;
   localparam int N_SC       = 12;
   localparam int BIN_OFFSET = 10;
   localparam int ISC_MAX    = 18;

   typedef logic signed [DATA_W-1:0] sample_t;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      COLLECT = 2'd1,
      OUTPUT  = 2'd2
   } state_t;

endpackage

// File: rtl/resource_mapper_isc_decode.sv
// Isc -> tone allocation (tone count, first subcarrier) plus invalid flag.
module resource_mapper_isc_decode
   import resource_mapper_pkg::*;
(
   input  logic [5:0] i_Isc,
   output logic [3:0] o_n_tones,
   output logic [3:0] o_start_sc,
   output logic       o_isc_err
);

   // Isc 12..15 share the low two bits as the 3-tone group index.
   logic [1:0] grp3;
   assign grp3 = i_Isc[1:0];

   // Range decode of the subcarrier indication.
   always_comb begin
      o_n_tones  = 4'd0;
      o_start_sc = 4'd0;
      o_isc_err  = 1'b0;
      if (i_Isc < 6'd12) begin
         o_n_tones  = 4'd1;
         o_start_sc = i_Isc[3:0];
      end else if (i_Isc < 6'd16) begin
         o_n_tones  = 4'd3;
         o_start_sc = {1'b0, grp3, 1'b0} + {2'b00, grp3};
      end else if (i_Isc < 6'(ISC_MAX)) begin
         o_n_tones  = 4'd6;
         o_start_sc = i_Isc[0] ? 4'd6 : 4'd0;
      end else if (i_Isc == 6'(ISC_MAX)) begin
         o_n_tones  = 4'd12;
         o_start_sc = 4'd0;
      end else begin
         o_isc_err  = 1'b1;
      end
   end

endmodule

// File: rtl/resource_mapper_tx.sv
// Collects modulated uplink symbols and places them on the Isc-selected
// subcarriers of one 16-bin IFFT frame.
//
// state   | meaning
// IDLE    | waiting for the first symbol of a frame; Isc decoded here
// COLLECT | accepting the remaining symbols of a multi-tone frame
// OUTPUT  | frame presented to the IFFT, held until accepted
module resource_mapper_tx
   import resource_mapper_pkg::*;
(
   input  logic                          i_clk,
   input  logic                          i_rst,
   input  logic [5:0]                    i_Isc,
   input  logic                          i_valid,
   input  logic [DATA_W-1:0]             i_sym_real,
   input  logic [DATA_W-1:0]             i_sym_imag,
   output logic                          o_ready,
   output logic [N_FFT-1:0][DATA_W-1:0]  o_IFFT_REAL,
   output logic [N_FFT-1:0][DATA_W-1:0]  o_IFFT_IMAGINARY,
   output logic                          o_valid,
   input  logic                          i_ready,
   output logic [3:0]                    o_tone_count,
   output logic                          o_isc_err
);

   state_t     state_q, state_d;
   logic [3:0] n_tones_q, n_tones_d;
   logic [3:0] start_sc_q, start_sc_d;
   logic [3:0] cnt_q, cnt_d;
   logic [3:0] tone_count_q, tone_count_d;
   logic       isc_err_q, isc_err_d;
   sample_t    buf_re_q [N_SC];
   sample_t    buf_im_q [N_SC];
   logic [N_FFT-1:0][DATA_W-1:0] frame_re_q, frame_re_d;
   logic [N_FFT-1:0][DATA_W-1:0] frame_im_q, frame_im_d;

   logic [3:0] dec_n, dec_start;
   logic       dec_err;
   logic       idle, in_xfer, out_xfer, accept, last;
   logic [3:0] n_eff, start_eff, cnt_eff;
   logic [4:0] bin_sum;

   resource_mapper_isc_decode u_isc_decode (
      .i_Isc      (i_Isc),
      .o_n_tones  (dec_n),
      .o_start_sc (dec_start),
      .o_isc_err  (dec_err)
   );

   assign idle      = (state_q == IDLE);
   assign o_ready   = !i_rst && (state_q != OUTPUT);
   assign o_valid   = (state_q == OUTPUT);
   assign in_xfer   = i_valid && o_ready;
   assign out_xfer  = o_valid && i_ready;
   // The first symbol of a frame uses the live decode; later ones the latched allocation.
   assign n_eff     = idle ? dec_n     : n_tones_q;
   assign start_eff = idle ? dec_start : start_sc_q;
   assign cnt_eff   = idle ? 4'd0      : cnt_q;
   assign accept    = in_xfer && !(idle && dec_err);
   assign last      = accept && ((cnt_eff + 4'd1) == n_eff);

   assign o_IFFT_REAL      = frame_re_q;
   assign o_IFFT_IMAGINARY = frame_im_q;
   assign o_tone_count     = tone_count_q;
   assign o_isc_err        = isc_err_q;

   // Frame assembly: the symbol arriving with the last transfer bypasses the buffer.
   always_comb begin
      frame_re_d = frame_re_q;
      frame_im_d = frame_im_q;
      bin_sum    = 5'd0;
      if (last) begin
         frame_re_d = '0;
         frame_im_d = '0;
         for (int j = 0; j < N_SC; j++) begin
            if (4'(j) < n_eff) begin
               bin_sum = {1'b0, start_eff} + 5'(j) + 5'(BIN_OFFSET);
               frame_re_d[bin_sum[3:0]] = (4'(j) == cnt_eff) ? i_sym_real : buf_re_q[j];
               frame_im_d[bin_sum[3:0]] = (4'(j) == cnt_eff) ? i_sym_imag : buf_im_q[j];
            end
         end
      end else if (out_xfer) begin
         frame_re_d = '0;
         frame_im_d = '0;
      end
   end

   // Next-state logic for the collect/output sequence.
   always_comb begin
      state_d      = state_q;
      n_tones_d    = n_tones_q;
      start_sc_d   = start_sc_q;
      cnt_d        = cnt_q;
      tone_count_d = tone_count_q;
      isc_err_d    = 1'b0;
      case (state_q)
         IDLE: begin
            if (in_xfer) begin
               if (dec_err) begin
                  isc_err_d = 1'b1;
               end else begin
                  n_tones_d  = dec_n;
                  start_sc_d = dec_start;
                  cnt_d      = 4'd1;
                  if (last) begin
                     state_d      = OUTPUT;
                     tone_count_d = dec_n;
                  end else begin
                     state_d      = COLLECT;
                  end
               end
            end
         end
         COLLECT: begin
            if (in_xfer) begin
               cnt_d = cnt_q + 4'd1;
               if (last) begin
                  state_d      = OUTPUT;
                  tone_count_d = n_tones_q;
               end
            end
         end
         OUTPUT: begin
            if (i_ready) begin
               state_d      = IDLE;
               tone_count_d = 4'd0;
               cnt_d        = 4'd0;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // Control and frame registers.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state_q      <= IDLE;
         n_tones_q    <= 4'd0;
         start_sc_q   <= 4'd0;
         cnt_q        <= 4'd0;
         tone_count_q <= 4'd0;
         isc_err_q    <= 1'b0;
         frame_re_q   <= '0;
         frame_im_q   <= '0;
      end else begin
         state_q      <= state_d;
         n_tones_q    <= n_tones_d;
         start_sc_q   <= start_sc_d;
         cnt_q        <= cnt_d;
         tone_count_q <= tone_count_d;
         isc_err_q    <= isc_err_d;
         frame_re_q   <= frame_re_d;
         frame_im_q   <= frame_im_d;
      end
   end

   // Symbol buffer, written at the running tone index.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         for (int j = 0; j < N_SC; j++) begin
            buf_re_q[j] <= '0;
            buf_im_q[j] <= '0;
         end
      end else if (accept) begin
         buf_re_q[cnt_eff] <= i_sym_real;
         buf_im_q[cnt_eff] <= i_sym_imag;
      end
   end

endmodule

// File: tb/tb_resource_mapper_tx.sv
// Directed bench for resource_mapper_tx: table of frame vectors plus
// hand-written reset, invalid-Isc and abort sequences.
module tb_resource_mapper_tx;
   import resource_mapper_pkg::*;

   logic                         i_clk;
   logic                         i_rst;
   logic [5:0]                   i_Isc;
   logic                         i_valid;
   logic [DATA_W-1:0]            i_sym_real;
   logic [DATA_W-1:0]            i_sym_imag;
   logic                         o_ready;
   logic [N_FFT-1:0][DATA_W-1:0] o_IFFT_REAL;
   logic [N_FFT-1:0][DATA_W-1:0] o_IFFT_IMAGINARY;
   logic                         o_valid;
   logic                         i_ready;
   logic [3:0]                   o_tone_count;
   logic                         o_isc_err;

   int checks = 0;
   int errors = 0;

   typedef struct {
      logic [5:0] isc;
      int         n;
      int         re0;
      int         im0;
      int         im_step;
      logic [5:0] alt_isc;
      int         hold;
      int         first_bin;
   } vec_t;

   vec_t vecs[8];

   resource_mapper_tx dut (
      .i_clk            (i_clk),
      .i_rst            (i_rst),
      .i_Isc            (i_Isc),
      .i_valid          (i_valid),
      .i_sym_real       (i_sym_real),
      .i_sym_imag       (i_sym_imag),
      .o_ready          (o_ready),
      .o_IFFT_REAL      (o_IFFT_REAL),
      .o_IFFT_IMAGINARY (o_IFFT_IMAGINARY),
      .o_valid          (o_valid),
      .i_ready          (i_ready),
      .o_tone_count     (o_tone_count),
      .o_isc_err        (o_isc_err)
   );

   initial i_clk = 1'b0;
   always #5 i_clk = ~i_clk;

   task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge i_clk);
      #1;
   endtask

   task automatic run_vec(input vec_t v, input string tag);
      logic [N_FFT-1:0][DATA_W-1:0] er, ei;
      int off;
      for (int b = 0; b < N_FFT; b++) begin
         off = (b - v.first_bin) & 15;
         if (off < v.n) begin
            er[b] = 16'(v.re0 + off);
            ei[b] = 16'(v.im0 + off * v.im_step);
         end else begin
            er[b] = '0;
            ei[b] = '0;
         end
      end
      i_Isc   = v.isc;
      i_ready = (v.hold == 0);
      for (int k = 0; k < v.n; k++) begin
         i_valid    = 1'b1;
         i_sym_real = 16'(v.re0 + k);
         i_sym_imag = 16'(v.im0 + k * v.im_step);
         if (k == 1) i_Isc = v.alt_isc;
         chk({tag, "_ready_in"}, 256'(o_ready), 256'(1'b1));
         chk({tag, "_valid_early"}, 256'(o_valid), 256'(1'b0));
         tick();
      end
      i_valid = 1'b0;
      chk({tag, "_valid"}, 256'(o_valid), 256'(1'b1));
      chk({tag, "_tones"}, 256'(o_tone_count), 256'(v.n));
      chk({tag, "_real"}, 256'(o_IFFT_REAL), 256'(er));
      chk({tag, "_imag"}, 256'(o_IFFT_IMAGINARY), 256'(ei));
      for (int h = 0; h < v.hold; h++) begin
         i_valid    = 1'b1;
         i_sym_real = 16'hdead;
         i_sym_imag = 16'hbeef;
         tick();
         chk({tag, "_bp_ready"}, 256'(o_ready), 256'(1'b0));
         chk({tag, "_bp_valid"}, 256'(o_valid), 256'(1'b1));
         chk({tag, "_bp_real"}, 256'(o_IFFT_REAL), 256'(er));
         chk({tag, "_bp_imag"}, 256'(o_IFFT_IMAGINARY), 256'(ei));
      end
      i_valid = 1'b0;
      i_ready = 1'b1;
      tick();
      i_ready = 1'b0;
      chk({tag, "_done_valid"}, 256'(o_valid), 256'(1'b0));
      chk({tag, "_done_tones"}, 256'(o_tone_count), 256'(0));
      chk({tag, "_done_real"}, 256'(o_IFFT_REAL), 256'(0));
      chk({tag, "_done_imag"}, 256'(o_IFFT_IMAGINARY), 256'(0));
      chk({tag, "_done_ready"}, 256'(o_ready), 256'(1'b1));
   endtask

   initial begin
      vecs[0] = '{isc: 6'd18, n: 12, re0: 1,     im0: -1,     im_step: -1, alt_isc: 6'd18, hold: 0, first_bin: 10};
      vecs[1] = '{isc: 6'd5,  n: 1,  re0: 256,   im0: 512,    im_step: 0,  alt_isc: 6'd5,  hold: 0, first_bin: 15};
      vecs[2] = '{isc: 6'd13, n: 3,  re0: 1,     im0: -32768, im_step: 1,  alt_isc: 6'd13, hold: 0, first_bin: 13};
      vecs[3] = '{isc: 6'd17, n: 6,  re0: 100,   im0: -200,   im_step: 7,  alt_isc: 6'd2,  hold: 0, first_bin: 0};
      vecs[4] = '{isc: 6'd11, n: 1,  re0: 32767, im0: -32768, im_step: 0,  alt_isc: 6'd11, hold: 5, first_bin: 5};
      vecs[5] = '{isc: 6'd12, n: 3,  re0: -5,    im0: 9,      im_step: -3, alt_isc: 6'd40, hold: 0, first_bin: 10};
      vecs[6] = '{isc: 6'd15, n: 3,  re0: 1000,  im0: 0,      im_step: 0,  alt_isc: 6'd15, hold: 0, first_bin: 3};
      vecs[7] = '{isc: 6'd16, n: 6,  re0: -1,    im0: 1,      im_step: 1,  alt_isc: 6'd63, hold: 2, first_bin: 10};

      // Reset held with upstream pushing.
      i_rst = 1'b1; i_valid = 1'b1; i_Isc = 6'd5; i_ready = 1'b0;
      i_sym_real = 16'd7; i_sym_imag = 16'd9;
      for (int c = 0; c < 3; c++) begin
         tick();
         chk("rst_ready", 256'(o_ready), 256'(1'b0));
         chk("rst_valid", 256'(o_valid), 256'(1'b0));
         chk("rst_real", 256'(o_IFFT_REAL), 256'(0));
         chk("rst_tones", 256'(o_tone_count), 256'(0));
         chk("rst_err", 256'(o_isc_err), 256'(1'b0));
      end
      i_rst = 1'b0; i_valid = 1'b0;
      tick();
      chk("rel_ready", 256'(o_ready), 256'(1'b1));
      chk("rel_valid", 256'(o_valid), 256'(1'b0));

      // Invalid Isc values: single-cycle error pulse, nothing produced.
      for (int t = 0; t < 3; t++) begin
         i_Isc = (t == 0) ? 6'd20 : (t == 1) ? 6'd63 : 6'd19;
         i_valid = 1'b1; i_sym_real = 16'h1234; i_sym_imag = 16'h5678;
         tick();
         i_valid = 1'b0;
         chk("inv_err", 256'(o_isc_err), 256'(1'b1));
         chk("inv_valid", 256'(o_valid), 256'(1'b0));
         chk("inv_ready", 256'(o_ready), 256'(1'b1));
         tick();
         chk("inv_err_clear", 256'(o_isc_err), 256'(1'b0));
         chk("inv_valid2", 256'(o_valid), 256'(1'b0));
      end

      for (int i = 0; i < 8; i++) run_vec(vecs[i], $sformatf("v%0d", i));

      // Reset in the middle of a 12-tone collection.
      i_Isc = 6'd18;
      for (int k = 0; k < 4; k++) begin
         i_valid = 1'b1; i_sym_real = 16'(16'h7000 + k); i_sym_imag = 16'(16'h0700 + k);
         tick();
      end
      i_valid = 1'b1; i_rst = 1'b1;
      tick();
      chk("abort_valid", 256'(o_valid), 256'(1'b0));
      chk("abort_ready", 256'(o_ready), 256'(1'b0));
      i_rst = 1'b0; i_valid = 1'b0;
      for (int c = 0; c < 12; c++) begin
         tick();
         chk("abort_no_valid", 256'(o_valid), 256'(1'b0));
      end
      run_vec('{isc: 6'd18, n: 12, re0: 50, im0: 3, im_step: 2, alt_isc: 6'd0, hold: 0, first_bin: 10}, "after_abort");

      // Reset while a frame is pending drops it.
      i_Isc = 6'd0; i_valid = 1'b1; i_sym_real = 16'h0042; i_sym_imag = 16'h0024;
      tick();
      i_valid = 1'b0;
      chk("pend_valid", 256'(o_valid), 256'(1'b1));
      i_rst = 1'b1; i_ready = 1'b0;
      tick();
      i_rst = 1'b0;
      chk("pend_drop_valid", 256'(o_valid), 256'(1'b0));
      chk("pend_drop_real", 256'(o_IFFT_REAL), 256'(0));
      tick();
      chk("pend_after_valid", 256'(o_valid), 256'(1'b0));
      chk("pend_after_ready", 256'(o_ready), 256'(1'b1));

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/resource_mapper_tx.md
Name: resource_mapper_tx

Overview:
- Transmit-side counterpart of the receive resource demapper.
- Collects a stream of modulated NB-IoT uplink symbols and places them onto the subcarriers selected by Isc.
- Emits one 16-bin frequency-domain frame, real and imaginary planes, to the 16-point IFFT.
- Sits between the modulator (upstream) and the IFFT (downstream), with valid/ready handshakes on both sides.

Parameters:
- DATA_W, 16: sample width, signed two's complement.
- N_FFT, 16: IFFT bins per frame.
- N_SC, 12: maximum tones per frame (symbol buffer depth).
- BIN_OFFSET, 10: subcarrier k maps to bin (k+BIN_OFFSET) mod N_FFT.

Ports:
- i_clk  in  1  clock. One clock domain.
- i_rst  in  1  synchronous reset, active-high.
- i_Isc  in  6  subcarrier indication. Sampled only on the first accepted symbol of a frame.
- i_valid  in  1  upstream symbol valid.
- i_sym_real  in  DATA_W  symbol, real part.
- i_sym_imag  in  DATA_W  symbol, imaginary part.
- o_ready  out  1  mapper can accept a symbol.
- o_IFFT_REAL  out  DATA_W x N_FFT  frame, real plane, bins [15:0].
- o_IFFT_IMAGINARY  out  DATA_W x N_FFT  frame, imaginary plane, bins [15:0].
- o_valid  out  1  frame valid.
- i_ready  in  1  IFFT accepts the frame.
- o_tone_count  out  4  tones in the current frame (1/3/6/12). 0 when o_valid=0.
- o_isc_err  out  1  one-cycle pulse when an invalid Isc is presented.

Behaviour:
- Clock and reset: one clock. Reset is synchronous, active-high.
- Reset values: state IDLE, o_valid=0, o_tone_count=0, o_isc_err=0, all frame bins 0, buffer and counters 0. o_ready=0 while i_rst=1.
- Isc decode:
  - 0..11: 1 tone at start_sc=Isc.
  - 12..15: 3 tones, start_sc=3*(Isc-12).
  - 16..17: 6 tones, start_sc=6*(Isc-16).
  - 18: 12 tones, start_sc=0.
  - 19..63: invalid.
- Transfers: an input transfer is i_valid&&o_ready. An output transfer is o_valid&&i_ready.
- FSM states:
  - IDLE: o_ready=1.
    - On a transfer, decode i_Isc.
    - Invalid Isc: o_isc_err=1 next cycle for one cycle, symbol discarded, stay IDLE.
    - Valid Isc: latch n_tones and start_sc, store symbol at buf[0], cnt=1. Go to OUTPUT if n_tones==1, else COLLECT.
  - COLLECT: o_ready=1.
    - Each transfer stores to buf[cnt], cnt++. i_Isc is ignored.
    - The transfer that makes cnt==n_tones goes to OUTPUT.
  - OUTPUT: o_ready=0, o_valid=1, o_tone_count=n_tones.
    - Frame outputs stay stable until an output transfer.
    - On transfer: next cycle IDLE, o_valid=0, frame bins cleared to 0, o_tone_count=0.
- Frame build: registered on the cycle of the last input transfer.
  - For j in 0..n_tones-1: bin (start_sc+j+BIN_OFFSET) mod N_FFT = buf[j].
  - All other bins are 0. Bins 6..9 are always 0 (guard).
  - Index arithmetic is 5-bit, modulo 16. No scaling or saturation; samples pass through bit-exact.
- Latency and throughput:
  - o_valid rises the cycle after the last symbol is accepted.
  - At least one bubble after the handoff: o_ready returns 1 the cycle after the output transfer.
  - Minimum frame period is n_tones+1 cycles.
- Boundary conditions:
  - i_valid with o_ready=0 is ignored; upstream must hold.
  - i_Isc changes mid-frame have no effect.
  - i_rst during COLLECT or OUTPUT drops the partial or pending frame next cycle; no o_valid is produced for it.
  - i_rst has priority over all simultaneous events.
  - i_ready while o_valid=0 has no effect.

Decomposition:
- Package resource_mapper_pkg:
  - constants DATA_W, N_FFT, N_SC, BIN_OFFSET, ISC_MAX=18.
  - typedef sample_t (logic signed [DATA_W-1:0]).
  - enum state_t {IDLE, COLLECT, OUTPUT}.
- Sub-module resource_mapper_isc_decode:
  - combinational, i_Isc -> n_tones[3:0], start_sc[3:0], isc_err.
  - Reused by the TX control path.

Test Plan:
- Reset: hold i_rst 3 cycles with i_valid=1 -> o_ready=0, o_valid=0, all bins 0. Release -> o_ready=1 next cycle.
- Isc=18, 12 symbols real=k+1, imag=-(k+1), k=0..11, back-to-back:
  - o_valid the cycle after the 12th accept, o_tone_count=12.
  - Bins 10..15 real = 1..6, bins 0..5 real = 7..12, bins 6..9 = 0, imaginary negated.
- Single tone and 3 tones:
  - Isc=5, symbol (0x0100, 0x0200) -> only bin 15 non-zero, o_tone_count=1, o_valid 1 cycle after accept.
  - Isc=13, symbols 1,2,3 -> bins 13,14,15 = 1,2,3.
- Six tones with mid-frame Isc change: Isc=17, 6 symbols, i_Isc set to 2 after the first -> bins 0..5 filled, o_tone_count=6.
- Invalid Isc and backpressure:
  - Isc=20 -> o_isc_err single pulse, no o_valid, state stays IDLE.
  - Then hold i_ready=0 for 5 cycles after o_valid -> frame bit-stable, o_ready=0, upstream symbols not consumed.
- Reset mid-collect: assert i_rst after 4 of 12 symbols (Isc=18) -> no o_valid. A following full 12-symbol frame maps correctly with no residue from the aborted one.
